// File: rtl/tri_csa_resolve.sv
// Resolves a carry-save operand pair into a binary sum, CHUNK bits per cycle,
// with a valid/ready handshake on both sides.
module tri_csa_resolve #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_car,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] car_q, car_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic [CHUNK:0]   chunk_add;
  logic [31:0]      base;
  logic             last_chunk;

  assign last_chunk = (k_q == K_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = ADD;
      ADD:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // One CHUNK-wide ripple add per ADD cycle; unwritten result chunks keep old data.
  always_comb begin
    sum_d     = sum_q;
    car_d     = car_q;
    res_d     = res_q;
    cout_d    = cout_q;
    k_d       = k_q;
    c_d       = c_q;
    base      = 32'(k_q) * 32'(CHUNK);
    chunk_add = {1'b0, sum_q[base +: CHUNK]} + {1'b0, car_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, c_q};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_d = in_sum;
          car_d = in_car;
          c_d   = in_cin;
          k_d   = '0;
        end
      end
      ADD: begin
        res_d[base +: CHUNK] = chunk_add[CHUNK-1:0];
        c_d                  = chunk_add[CHUNK];
        if (last_chunk) begin
          cout_d = chunk_add[CHUNK];
          k_d    = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      car_q  <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      k_q    <= '0;
      c_q    <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      car_q  <= car_d;
      res_q  <= res_d;
      cout_q <= cout_d;
      k_q    <= k_d;
      c_q    <= c_d;
    end
  end

  assign out_res  = res_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_tri_csa_resolve.sv
// Directed bench for tri_csa_resolve: default 64/16 instance plus a 16/16 instance.
module tb_tri_csa_resolve;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [63:0] in_sum, in_car, out_res;

  logic        in_valid_n, in_ready_n, in_cin_n, out_valid_n, out_ready_n, out_cout_n;
  logic [15:0] in_sum_n, in_car_n, out_res_n;

  int total = 0;
  int bad   = 0;

  tri_csa_resolve dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_car(in_car), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_cout(out_cout)
  );

  tri_csa_resolve #(.WIDTH(16), .CHUNK(16)) dut_n (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_n), .in_ready(in_ready_n),
    .in_sum(in_sum_n), .in_car(in_car_n), .in_cin(in_cin_n),
    .out_valid(out_valid_n), .out_ready(out_ready_n),
    .out_res(out_res_n), .out_cout(out_cout_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every step lands 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [64:0] observed,
                             input logic [64:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one operand pair in IDLE, then counts cycles until out_valid.
  task automatic applyStimulus(input logic [63:0] s, input logic [63:0] c,
                               input logic ci, output int lat);
    in_sum   = s;
    in_car   = c;
    in_cin   = ci;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  logic [64:0] exp_q[$];
  logic [64:0] held;
  int lat, accepted, cyc, last_acc;
  logic seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sum = '0; in_car = '0; in_cin = 1'b0;
    in_valid_n = 1'b0; out_ready_n = 1'b0;
    in_sum_n = '0; in_car_n = '0; in_cin_n = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset in_ready", 65'(in_ready), 65'(1));
    checkOutput("reset out_valid", 65'(out_valid), 65'(0));
    checkOutput("reset out_res", 65'(out_res), 65'(0));
    checkOutput("reset out_cout", 65'(out_cout), 65'(0));

    // in_valid during reset must not be captured
    rst = 1'b1; in_valid = 1'b1; in_sum = 64'h55; in_car = 64'h1;
    tick();
    checkOutput("rst held in_ready", 65'(in_ready), 65'(1));
    rst = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checkOutput("no capture under rst", 65'(seen), 65'(0));

    // all-ones sum plus one wraps to zero with carry out
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checkOutput("wrap latency", 65'(lat), 65'(5));
    checkOutput("wrap result", {out_cout, out_res}, {1'b1, 64'h0});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("wrap release in_ready", 65'(in_ready), 65'(1));
    checkOutput("wrap release out_valid", 65'(out_valid), 65'(0));

    // carry ripples across a chunk boundary; then stall with in_valid high
    applyStimulus(64'h0000_0001_0000_FFFF, 64'h1, 1'b1, lat);
    checkOutput("ripple latency", 65'(lat), 65'(5));
    checkOutput("ripple result", {out_cout, out_res}, {1'b0, 64'h0000_0001_0001_0001});
    held = {out_cout, out_res};
    in_valid = 1'b1; in_sum = 64'hDEAD_BEEF_0000_0000; in_car = 64'h7; in_cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall out_valid", 65'(out_valid), 65'(1));
      checkOutput("stall in_ready", 65'(in_ready), 65'(0));
      checkOutput("stall hold", {out_cout, out_res}, {1'b0, 64'h0000_0001_0001_0001});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("stall release in_ready", 65'(in_ready), 65'(1));
    checkOutput("stall release out_valid", 65'(out_valid), 65'(0));
    tick();
    checkOutput("stall no late capture", 65'(in_ready), 65'(1));
    checkOutput("stall result kept", {out_cout, out_res}, held);

    // reset in the second ADD cycle abandons the transaction
    in_sum = 64'h1234_5678_9ABC_DEF0; in_car = 64'h1111; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort in_ready", 65'(in_ready), 65'(1));
    checkOutput("abort out_valid", 65'(out_valid), 65'(0));
    checkOutput("abort out_res", 65'(out_res), 65'(0));
    checkOutput("abort out_cout", 65'(out_cout), 65'(0));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checkOutput("abort no out_valid", 65'(seen), 65'(0));
    out_ready = 1'b1;
    applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, lat);
    checkOutput("msb latency", 65'(lat), 65'(5));
    checkOutput("msb result", {out_cout, out_res}, {1'b1, 64'h0});
    tick();

    // back-to-back random traffic, in order, one accept every 6 cycles
    accepted = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1;
    while ((accepted < 100 || exp_q.size() > 0) && cyc < 2000) begin
      if (accepted == 100) in_valid = 1'b0;
      if (out_valid) begin
        if (exp_q.size() > 0) checkOutput("stream result", {out_cout, out_res}, exp_q.pop_front());
        else checkOutput("stream extra result", 65'(1), 65'(0));
      end
      if (in_ready && accepted < 100) begin
        in_sum   = {$urandom(), $urandom()};
        in_car   = {$urandom(), $urandom()};
        in_cin   = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        exp_q.push_back(65'(in_sum) + 65'(in_car) + 65'(in_cin));
        if (last_acc >= 0) checkOutput("stream interval", 65'(cyc - last_acc), 65'(6));
        last_acc = cyc;
        accepted++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("stream accepted", 65'(accepted), 65'(100));
    checkOutput("stream drained", 65'(exp_q.size()), 65'(0));

    // single-chunk instance
    in_sum_n = 16'hFFFF; in_car_n = 16'h0001; in_cin_n = 1'b1; in_valid_n = 1'b1;
    tick();
    in_valid_n = 1'b0;
    lat = 1;
    while (!out_valid_n && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("narrow latency", 65'(lat), 65'(2));
    checkOutput("narrow result", {48'h0, out_cout_n, out_res_n}, {48'h0, 1'b1, 16'h0001});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tri_csa_resolve.md
TRI_CSA_RESOLVE -- requirements
Module: tri_csa_resolve

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16: bits resolved per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  carry-save operand pair present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port in_sum  input  WIDTH  sum vector from the CSA tree.
REQ-008 SHALL have port in_car  input  WIDTH  carry vector, already weight-aligned by the producer (bit i has weight 2^i).
REQ-009 SHALL have port in_cin  input  1  carry-in at bit 0.
REQ-010 SHALL have port out_valid  output  1  resolved result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_res  output  WIDTH  binary result, (in_sum + in_car + in_cin) mod 2^WIDTH.
REQ-013 SHALL have port out_cout  output  1  carry-out of bit WIDTH-1.

Function
REQ-014 SHALL implement three states: IDLE, ADD, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are registered-state decodes with no combinational input-to-output paths.
REQ-016 In IDLE, when in_valid=1, SHALL capture in_sum, in_car, in_cin, set chunk index k=0, running carry c=in_cin, and go to ADD.
REQ-017 In ADD, each cycle SHALL compute in_sum[k] + in_car[k] + c over CHUNK bits (chunk k = bits k*CHUNK+CHUNK-1 : k*CHUNK), write the low CHUNK bits into out_res chunk k, set c to the chunk carry-out, and increment k.
REQ-018 After the ADD cycle with k = NCHUNK-1, SHALL load out_cout = c and go to DONE.
REQ-019 Latency SHALL be exactly NCHUNK+1 cycles from the accepting IDLE cycle to the first cycle with out_valid=1; with WIDTH=CHUNK, one ADD cycle.
REQ-020 In DONE, out_res and out_cout SHALL hold stable while out_ready=0; when out_ready=1, SHALL return to IDLE on the next edge.
REQ-021 in_valid SHALL be ignored outside IDLE; no operand is captured in ADD or DONE.
REQ-022 Back-to-back throughput SHALL be one result per NCHUNK+2 cycles with in_valid and out_ready held high.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; overflow is reported only via out_cout.
REQ-024 out_res chunks not yet written in the current ADD sequence SHALL retain their prior values; they are don't-care while out_valid=0.

Reset
REQ-025 With rst=1 at an edge, SHALL enter IDLE and clear out_res=0, out_cout=0, k=0, c=0, and captured operands; after that edge out_valid=0 and in_ready=1.
REQ-026 rst SHALL take priority over every other input in any state; a reset in ADD or DONE SHALL discard the transaction and produce no out_valid for it.
REQ-027 While rst=1, in_ready SHALL be 1 (IDLE decode), but no capture SHALL occur in that cycle.

Verification (WIDTH=64, CHUNK=16)
REQ-028 in_sum=0xFFFF_FFFF_FFFF_FFFF, in_car=0x1, in_cin=0 -> out_valid rises 5 cycles after the accept cycle; out_res=0x0, out_cout=1.
REQ-029 in_sum=0x0000_0001_0000_FFFF, in_car=0x1, in_cin=1 -> out_res=0x0000_0001_0001_0001, out_cout=0.
REQ-030 Result pending with out_ready=0 for 5 cycles and in_valid=1 throughout -> out_valid=1, out_res and out_cout unchanged, in_ready=0, no new capture; out_ready=1 -> IDLE next cycle.
REQ-031 rst=1 during the second ADD cycle -> next cycle in_ready=1, out_valid=0, out_res=0, out_cout=0; the following transaction with in_sum=in_car=0x8000_0000_0000_0000 gives out_res=0, out_cout=1.
REQ-032 in_valid and out_ready held 1 with 100 random operand sets -> accepts exactly every 6 cycles; every result equals in_sum+in_car+in_cin (65-bit) and results appear in input order.
REQ-033 With parameter override WIDTH=CHUNK=16: in_sum=0xFFFF, in_car=0x0001, in_cin=1 -> out_valid 2 cycles after accept, out_res=0x0001, out_cout=1.
